// File: rtl/addr_gen_pkg.sv
// Shared types for the 2D address generator: FSM encoding and the latched job descriptor.
// The col_major field exists only when ADDR_GEN_COL_MAJOR_EN is defined.
package addr_gen_pkg;

    localparam int unsigned AW_DEF    = 12;
    localparam int unsigned CNT_W_DEF = AW_DEF + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    typedef struct packed {
        logic [AW_DEF-1:0]    base;
        logic [CNT_W_DEF-1:0] rows;
        logic [CNT_W_DEF-1:0] cols;
        logic [AW_DEF-1:0]    row_stride;
`ifdef ADDR_GEN_COL_MAJOR_EN
        logic                 col_major;
`endif
    } job_t;

endpackage

// File: rtl/index_counter.sv
// Wrapping loop index: counts 0..limit-1 on inc, with a registered flag marking the final index.
module index_counter #(
    parameter int unsigned AW    = 12,
    parameter int unsigned CNT_W = AW + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clear,
    input  logic             inc,
    input  logic [CNT_W-1:0] limit,
    output logic [AW-1:0]    count,
    output logic             at_limit
);

    // at_limit tracks count == limit-1 for the value being loaded, so it is ready with count
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count    <= '0;
            at_limit <= 1'b0;
        end else if (clear || (inc && at_limit)) begin
            count    <= '0;
            at_limit <= (limit == CNT_W'(1));
        end else if (inc) begin
            count    <= count + AW'(1);
            at_limit <= ((CNT_W'(count) + CNT_W'(2)) == limit);
        end
    end

endmodule

// File: rtl/addr_gen_2d.sv
// 2D address generator: walks a rows x cols window at base + row*row_stride + col (mod 2^AW).
// Define ADDR_GEN_COL_MAJOR_EN to add the col_major port for column-major traversal.
module addr_gen_2d
    import addr_gen_pkg::*;
#(
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned CNT_W = AW + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [AW-1:0]    base,
    input  logic [CNT_W-1:0] rows,
    input  logic [CNT_W-1:0] cols,
    input  logic [AW-1:0]    row_stride,
`ifdef ADDR_GEN_COL_MAJOR_EN
    input  logic             col_major,
`endif
    output logic             busy,
    output logic             valid,
    input  logic             ready,
    output logic [AW-1:0]    addr,
    output logic [AW-1:0]    row,
    output logic [AW-1:0]    col,
    output logic             last,
    output logic             done
);

    state_t          state;
    job_t            job;
    job_t            job_in;
    logic [AW-1:0]   outer_base;
    logic            cm_in;
    logic            cm_job;
    logic            accept;
    logic            fire;
    logic            inner_wrap;
    logic [CNT_W-1:0] inner_limit;
    logic [CNT_W-1:0] outer_limit;
    logic [AW-1:0]   inner_step;
    logic [AW-1:0]   outer_step;
    logic [AW-1:0]   inner_count;
    logic [AW-1:0]   outer_count;
    logic            inner_at_limit;
    logic            outer_at_limit;

`ifdef ADDR_GEN_COL_MAJOR_EN
    assign cm_in  = col_major;
    assign cm_job = job.col_major;
`else
    assign cm_in  = 1'b0;
    assign cm_job = 1'b0;
`endif

    always_comb begin
        job_in            = '0;
        job_in.base       = AW_DEF'(base);
        job_in.rows       = CNT_W_DEF'(rows);
        job_in.cols       = CNT_W_DEF'(cols);
        job_in.row_stride = AW_DEF'(row_stride);
`ifdef ADDR_GEN_COL_MAJOR_EN
        job_in.col_major  = col_major;
`endif
    end

    assign accept     = (state == IDLE) && start;
    assign fire       = valid && ready;
    assign inner_wrap = fire && inner_at_limit;

    // Counters reload on the start cycle, so their limits come from the live inputs while idle
    always_comb begin
        if (state == IDLE) begin
            inner_limit = cm_in ? rows : cols;
            outer_limit = cm_in ? cols : rows;
        end else begin
            inner_limit = cm_job ? CNT_W'(job.rows) : CNT_W'(job.cols);
            outer_limit = cm_job ? CNT_W'(job.cols) : CNT_W'(job.rows);
        end
        inner_step = cm_job ? AW'(job.row_stride) : AW'(1);
        outer_step = cm_job ? AW'(1) : AW'(job.row_stride);
    end

    index_counter #(.AW(AW), .CNT_W(CNT_W)) u_inner (
        .CLK      (CLK),
        .RST      (RST),
        .clear    (accept),
        .inc      (fire),
        .limit    (inner_limit),
        .count    (inner_count),
        .at_limit (inner_at_limit)
    );

    index_counter #(.AW(AW), .CNT_W(CNT_W)) u_outer (
        .CLK      (CLK),
        .RST      (RST),
        .clear    (accept),
        .inc      (inner_wrap),
        .limit    (outer_limit),
        .count    (outer_count),
        .at_limit (outer_at_limit)
    );

    assign row  = cm_job ? inner_count : outer_count;
    assign col  = cm_job ? outer_count : inner_count;
    assign last = valid && inner_at_limit && outer_at_limit;

    // Job control; addr advances by inner_step, or restarts from the bumped outer base on a wrap
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            job        <= '0;
            outer_base <= '0;
            addr       <= '0;
            busy       <= 1'b0;
            valid      <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        job        <= job_in;
                        outer_base <= base;
                        addr       <= base;
                        if ((rows == '0) || (cols == '0)) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            valid <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (fire) begin
                        if (last) begin
                            state <= FINISH;
                            busy  <= 1'b0;
                            valid <= 1'b0;
                            done  <= 1'b1;
                        end else if (inner_at_limit) begin
                            outer_base <= outer_base + outer_step;
                            addr       <= outer_base + outer_step;
                        end else begin
                            addr <= addr + inner_step;
                        end
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_addr_gen_2d.sv
// Bench for addr_gen_2d: job table plus random jobs against an arithmetic traversal model.
module tb_addr_gen_2d;

    localparam int unsigned AW    = 12;
    localparam int unsigned CNT_W = AW + 1;
    localparam int          MAXC  = 20000;

    logic             CLK = 1'b0;
    logic             RST;
    logic             start;
    logic [AW-1:0]    base;
    logic [CNT_W-1:0] rows;
    logic [CNT_W-1:0] cols;
    logic [AW-1:0]    row_stride;
`ifdef ADDR_GEN_COL_MAJOR_EN
    logic             col_major;
`endif
    logic             busy;
    logic             valid;
    logic             ready;
    logic [AW-1:0]    addr;
    logic [AW-1:0]    row;
    logic [AW-1:0]    col;
    logic             last;
    logic             done;

    addr_gen_2d dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .base       (base),
        .rows       (rows),
        .cols       (cols),
        .row_stride (row_stride),
`ifdef ADDR_GEN_COL_MAJOR_EN
        .col_major  (col_major),
`endif
        .busy       (busy),
        .valid      (valid),
        .ready      (ready),
        .addr       (addr),
        .row        (row),
        .col        (col),
        .last       (last),
        .done       (done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int unsigned addr;
        int unsigned row;
        int unsigned col;
        bit          last;
    } elem_t;

    // mode: 0 = ready always high, 1 = ready 1,0,0 repeating, 2 = random ready
    typedef struct {
        int unsigned base;
        int unsigned rows;
        int unsigned cols;
        int unsigned stride;
        bit          cm;
        int          mode;
        int unsigned exp_n;
        int unsigned exp_last;
    } vec_t;

    elem_t exp_q[$];
    vec_t  tbl[$];
    int    vectors    = 0;
    int    miscompares = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input int unsigned b, input int unsigned r, input int unsigned c,
                                input int unsigned s, input bit cm, input int mode,
                                input int unsigned n, input int unsigned la);
        vec_t v;
        v.base = b; v.rows = r; v.cols = c; v.stride = s; v.cm = cm;
        v.mode = mode; v.exp_n = n; v.exp_last = la;
        return v;
    endfunction

    // Reference order of elements, straight from the address formula
    task automatic build_model(input vec_t v);
        elem_t e;
        exp_q.delete();
        if (v.cm) begin
            for (int c = 0; c < int'(v.cols); c++)
                for (int r = 0; r < int'(v.rows); r++) begin
                    e.addr = (v.base + r * v.stride + c) % 4096;
                    e.row = r; e.col = c;
                    e.last = (r == int'(v.rows) - 1) && (c == int'(v.cols) - 1);
                    exp_q.push_back(e);
                end
        end else begin
            for (int r = 0; r < int'(v.rows); r++)
                for (int c = 0; c < int'(v.cols); c++) begin
                    e.addr = (v.base + r * v.stride + c) % 4096;
                    e.row = r; e.col = c;
                    e.last = (r == int'(v.rows) - 1) && (c == int'(v.cols) - 1);
                    exp_q.push_back(e);
                end
        end
    endtask

    function automatic logic pick_ready(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 3 == 0);
        return 1'(($urandom & 1));
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_busy"},  busy,  0);
        check({tag, "_addr"},  addr,  0);
        check({tag, "_row"},   row,   0);
        check({tag, "_col"},   col,   0);
        check({tag, "_last"},  last,  0);
        check({tag, "_done"},  done,  0);
    endtask

    // Runs one job from a negedge; optional start injection mid-run and during FINISH
    task automatic run_job(input vec_t v, input int inject_at, input bit finish_start);
        int          n, idx, cyc;
        bit          stalled;
        elem_t       e;
        int unsigned p_addr, p_row, p_col, p_last, seen_last;
        build_model(v);
        n = exp_q.size();
        start = 1'b1;
        base = AW'(v.base); rows = CNT_W'(v.rows); cols = CNT_W'(v.cols);
        row_stride = AW'(v.stride);
`ifdef ADDR_GEN_COL_MAJOR_EN
        col_major = v.cm;
`endif
        @(negedge CLK);
        start = 1'b0;
        base = AW'($urandom); rows = CNT_W'($urandom); cols = CNT_W'($urandom);
        row_stride = AW'($urandom);
        idx = 0; cyc = 0; stalled = 0; seen_last = 0;
        p_addr = 0; p_row = 0; p_col = 0; p_last = 0;
        while (idx < n && cyc < MAXC) begin
            ready = pick_ready(v.mode, cyc);
            start = (cyc == inject_at);
            if (!valid) break;
            if (stalled) begin
                check("hold_addr", addr, p_addr);
                check("hold_row",  row,  p_row);
                check("hold_col",  col,  p_col);
                check("hold_last", last, p_last);
            end
            if (ready) begin
                e = exp_q[idx];
                check("addr", addr, e.addr);
                check("row",  row,  e.row);
                check("col",  col,  e.col);
                check("last", last, e.last);
                seen_last = addr;
                idx++;
            end
            stalled = !ready;
            p_addr = addr; p_row = row; p_col = col; p_last = last;
            @(negedge CLK);
            cyc++;
        end
        start = 1'b0;
        ready = 1'b0;
        check("handshakes", idx, v.exp_n);
        if (v.mode == 0 && n > 0) check("throughput_cycles", cyc, n);
        if (n > 0) check("last_addr", seen_last, v.exp_last);
        check("done_pulse", done, 1);
        check("end_busy", busy, 0);
        check("end_valid", valid, 0);
        if (finish_start) begin
            start = 1'b1; base = 12'h5A5; rows = 1; cols = 1;
        end
        @(negedge CLK);
        start = 1'b0;
        check("done_cleared", done, 0);
        check("idle_valid", valid, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        vec_t v;
        RST = 1'b1; start = 1'b0; ready = 1'b0;
        base = '0; rows = '0; cols = '0; row_stride = '0;
`ifdef ADDR_GEN_COL_MAJOR_EN
        col_major = 1'b0;
`endif
        repeat (3) @(negedge CLK);
        check_idle_outputs("in_reset");
        RST = 1'b0;
        @(negedge CLK);
        check_idle_outputs("post_reset");

        tbl.push_back(mk(32'h100, 2, 3, 8, 0, 0, 6, 32'h10A));
        tbl.push_back(mk(32'h100, 2, 3, 8, 0, 1, 6, 32'h10A));
        tbl.push_back(mk(32'h000, 0, 5, 3, 0, 0, 0, 0));
        tbl.push_back(mk(32'h123, 3, 0, 3, 0, 0, 0, 0));
        tbl.push_back(mk(32'hFFE, 1, 4, 32'h10, 0, 0, 4, 32'h001));
        tbl.push_back(mk(32'h055, 1, 1, 0, 0, 1, 1, 32'h055));
        tbl.push_back(mk(32'hF00, 3, 2, 32'h100, 0, 2, 6, 32'h101));
        tbl.push_back(mk(32'h321, 4, 3, 7, 0, 2, 12, 32'h338));
        tbl.push_back(mk(32'h000, 1, 4096, 0, 0, 0, 4096, 32'hFFF));
`ifdef ADDR_GEN_COL_MAJOR_EN
        tbl.push_back(mk(32'h000, 2, 2, 4, 1, 0, 4, 32'h005));
        tbl.push_back(mk(32'h020, 3, 2, 32'h10, 1, 1, 6, 32'h041));
`endif
        foreach (tbl[i]) run_job(tbl[i], -1, 1'b0);

        // start during RUN and during FINISH must both be ignored
        run_job(mk(32'h100, 2, 3, 8, 0, 0, 6, 32'h10A), 2, 1'b1);
        run_job(mk(32'h100, 2, 3, 8, 0, 1, 6, 32'h10A), 4, 1'b1);

        // Reset in the middle of the first row
        start = 1'b1; base = 12'h400; rows = 3; cols = 5; row_stride = 12'h40;
`ifdef ADDR_GEN_COL_MAJOR_EN
        col_major = 1'b0;
`endif
        @(negedge CLK);
        start = 1'b0; ready = 1'b1;
        repeat (2) @(negedge CLK);
        check("pre_reset_valid", valid, 1);
        check("pre_reset_addr", addr, 12'h402);
        #2 RST = 1'b1;
        #1 check_idle_outputs("async_reset");
        @(negedge CLK);
        RST = 1'b0; ready = 1'b0;
        @(negedge CLK);
        check_idle_outputs("after_release");
        run_job(mk(32'h0A0, 2, 2, 32'h20, 0, 0, 4, 32'h0C1), -1, 1'b0);

        // Random jobs against the model
        for (int k = 0; k < 30; k++) begin
            v.base = $urandom % 4096;
            v.rows = $urandom_range(0, 5);
            v.cols = $urandom_range(0, 5);
            v.stride = $urandom % 4096;
`ifdef ADDR_GEN_COL_MAJOR_EN
            v.cm = 1'($urandom & 1);
`else
            v.cm = 1'b0;
`endif
            v.mode = $urandom_range(0, 2);
            v.exp_n = v.rows * v.cols;
            v.exp_last = (v.exp_n == 0) ? 0 :
                         (v.base + (v.rows - 1) * v.stride + v.cols - 1) % 4096;
            run_job(v, -1, 1'($urandom & 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/addr_gen_2d.md
Name: addr_gen_2d

Overview:
Parametrised 2D address generator. Successor to the power-of-2 row/col counter.
- Arbitrary (non-power-of-2) row and column extents, programmable base and row stride.
- Start/done job control; valid/ready output stream.
- Sits between the MAC controller and the operand/result buffer address ports.

Parameters:
AW, 12, width of addresses, indices, extents and stride.
CNT_W, AW+1, extent width, so an extent of 2^AW is expressible.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  reset, asynchronous, active-high.
start  in  1  job request, sampled only in IDLE.
base  in  AW  start address, latched on accepted start.
rows  in  CNT_W  row extent (outer loop), latched on start.
cols  in  CNT_W  column extent (inner loop), latched on start.
row_stride  in  AW  address increment per row, latched on start.
busy  out  1  high in RUN.
valid  out  1  current addr/row/col element is valid.
ready  in  1  consumer accepts element when valid&&ready.
addr  out  AW  linear address.
row  out  AW  row index.
col  out  AW  column index.
last  out  1  current element is the final element of the job.
done  out  1  one-cycle pulse at job end.

Behaviour:
- Reset: asynchronous, active-high; RST=1 forces IDLE immediately. All outputs are 0 while RST is high and after release; latched job registers are cleared.
- State machine, encoding from the shared package:
  - IDLE: on start, latch base, rows, cols and row_stride.
    - If rows==0 or cols==0, go to FINISH; no element is emitted.
    - Otherwise go to RUN.
  - RUN: valid=1 and busy=1.
    - On valid&&ready with last=1, go to FINISH.
  - FINISH: done=1 for exactly one cycle, then IDLE. start is ignored in this state.
- Latency: first element (row=0, col=0, addr=base) is valid in the cycle after start is sampled.
- Traversal is row-major:
  - col increments on each handshake.
  - At col==cols-1, col returns to 0 and row increments.
  - last = (row==rows-1) && (col==cols-1).
- Address generation:
  - addr = base + row*row_stride + col, all modulo 2^AW.
  - Computed incrementally, with no multiplier: a row_base register adds row_stride on each row advance, and addr = row_base + col.
  - Wrap past 2^AW-1 is silent.
- Backpressure: while valid=1 and ready=0, addr, row, col and last hold stable.
- start while busy or in FINISH is ignored; no queuing.
- Inputs base, rows, cols and row_stride are don't-care outside the start cycle.
- Throughput: one element per cycle when ready is held high. There are no bubbles between rows.

Optional Feature:
ADDR_GEN_COL_MAJOR_EN
- Defined:
  - Adds input port col_major (1 bit), latched on start.
  - When the latched value is 1, traversal is column-major: row is the inner loop and col the outer loop.
  - addr = base + row*row_stride + col still holds; the incremental form becomes col_base += 1 per column, with addr = col_base + row_acc, where row_acc += row_stride per row.
  - last is unchanged in meaning (the final element emitted).
- Undefined: the port is absent and traversal is row-major only.

Decomposition:
- Package addr_gen_pkg:
  - state enum typedef {IDLE, RUN, FINISH}.
  - Job-descriptor struct typedef (base, rows, cols, row_stride, optional col_major).
  - Localparam defaults for AW.
- Sub-module index_counter:
  - Wrapping counter with inputs clear, inc and limit; outputs count and at_limit.
  - Instantiated twice, for the inner and outer loops.

Test Plan:
- Basic: AW=12, base=0x100, rows=2, cols=3, stride=8, ready=1 -> addr 0x100,0x101,0x102,0x108,0x109,0x10A on consecutive cycles; last on the 6th element; done the next cycle; busy low after that.
- Backpressure: same job with ready toggling 1,0,0,1,... -> outputs hold during ready=0; sequence is identical to Basic; exactly 6 handshakes.
- Zero extent: rows=0, cols=5 -> valid never asserts; done pulses one cycle after start; back to IDLE.
- Wrap: base=0xFFE, rows=1, cols=4 -> addr 0xFFE,0xFFF,0x000,0x001; row stays 0; last on 0x001.
- Reset/ignore:
  - start during RUN -> ignored; the job completes unchanged.
  - RST asserted mid-row -> outputs 0 immediately and state IDLE.
  - Fresh start after RST release -> begins at the new base.
- COL_MAJOR (macro defined): col_major=1, base=0, rows=2, cols=2, stride=4 -> addr 0,4,1,5; last on 5.
